// File: rtl/uart_fifo_transceiver.sv
// uart_fifo_transceiver: UART with TX/RX FIFOs, optional parity, 1/2 stop bits and a 16x oversampled receiver.
// Optional build macro UART_LOOPBACK_EN adds a loopback port that feeds the TX line into RX and holds txd high.
module uart_fifo_transceiver #(
    parameter int CLK_FREQ  = 11_059_200,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);
    localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TA  = $clog2(TX_DEPTH);
    localparam int RA  = $clog2(RX_DEPTH);
    localparam int RW  = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    if (DIV < 1) begin : g_div_chk
        $error("uart_fifo_transceiver: DIV < 1, BAUD too high for CLK_FREQ");
    end

    logic [DW-1:0]        div_q, div_d;
    logic                 tick;
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TA:0]          tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic                 tx_empty, tx_full, tx_push, tx_load, tx_line;
    logic [DATA_BITS-1:0] tx_head;
    state_t               tx_st_q, tx_st_d;
    logic [3:0]           tx_tk_q, tx_tk_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic [1:0]           sync_q, sync_d;
    logic                 rx_src, rx_s, rx_samp, rx_push, rx_perr, rx_ferr, rx_pop, rx_wr, rx_full;
    state_t               rx_st_q, rx_st_d;
    logic [3:0]           rx_ph_q, rx_ph_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_pb_q, rx_pb_d;
    logic [RW-1:0]        rx_mem [RX_DEPTH];
    logic [RW-1:0]        rx_head;
    logic [RA:0]          rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic                 ovr_q, ovr_d;

`ifdef UART_LOOPBACK_EN
    logic lb_q, lb_d;
    always_comb lb_d = loopback;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lb_q <= 1'b0;
        else     lb_q <= lb_d;
    end
    assign rx_src = lb_q ? tx_line : rxd;
    assign txd    = tx_line | lb_q;
`else
    assign rx_src = rxd;
    assign txd    = tx_line;
`endif

    assign tick     = div_q == DW'(DIV - 1);
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q ^ tx_rp_q) == {1'b1, {TA{1'b0}}};
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_head  = tx_mem[tx_rp_q[TA-1:0]];

    assign rx_s          = sync_q[1];
    assign rx_samp       = tick && rx_ph_q == 4'd7;
    assign rx_perr       = PARITY != 0 && ((^{rx_sh_q, rx_pb_q}) == (PARITY == 2));
    assign rx_ferr       = !rx_s;
    assign rx_valid      = rx_wp_q != rx_rp_q;
    assign rx_full       = (rx_wp_q ^ rx_rp_q) == {1'b1, {RA{1'b0}}};
    assign rx_pop        = rx_valid && rx_ready;
    assign rx_wr         = rx_push && (!rx_full || rx_pop);
    assign rx_head       = rx_mem[rx_rp_q[RA-1:0]];
    assign rx_data       = rx_head[DATA_BITS-1:0];
    assign rx_frame_err  = rx_valid && rx_head[DATA_BITS];
    assign rx_parity_err = rx_valid && rx_head[DATA_BITS+1];
    assign rx_overrun    = ovr_q;

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        sync_d  = {sync_q[0], rx_src};
        tx_wp_d = tx_wp_q + (TA+1)'(tx_push);
        tx_rp_d = tx_rp_q + (TA+1)'(tx_load);
        rx_wp_d = rx_wp_q + (RA+1)'(rx_wr);
        rx_rp_d = rx_rp_q + (RA+1)'(rx_pop);
        ovr_d   = rx_push && rx_full && !rx_pop;
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tk_d  = tx_tk_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_load  = 1'b0;
        tx_line  = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : tx_st_q == PAR ? tx_par_q : 1'b1;
        if (tick) tx_tk_d = tx_tk_q + 4'd1;
        if (tx_st_q == IDLE) tx_load = tick && !tx_empty;
        else if (tick && tx_tk_q == 4'd15) begin
            case (tx_st_q)
                START: tx_st_d = DATA;
                DATA: begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                        tx_st_d  = PARITY != 0 ? PAR : STOP;
                        tx_bit_d = '0;
                    end
                end
                PAR: tx_st_d = STOP;
                default: begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    // last stop bit: chain straight into the next frame when data is waiting
                    if (tx_bit_q == 3'(STOP_BITS - 1)) begin
                        tx_load = !tx_empty;
                        tx_st_d = IDLE;
                    end
                end
            endcase
        end
        if (tx_load) begin
            tx_st_d  = START;
            tx_tk_d  = '0;
            tx_bit_d = '0;
            tx_sh_d  = tx_head;
            tx_par_d = (PARITY == 1) ^ (^tx_head);
        end
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_ph_d  = rx_ph_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_pb_d  = rx_pb_q;
        rx_push  = 1'b0;
        if (tick) rx_ph_d = rx_ph_q + 4'd1;
        case (rx_st_q)
            IDLE: if (!rx_s) begin
                rx_st_d = START;
                rx_ph_d = '0;
            end
            START: if (rx_samp) begin
                rx_st_d  = rx_s ? IDLE : DATA;
                rx_bit_d = '0;
            end
            DATA: if (rx_samp) begin
                rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'(DATA_BITS - 1)) rx_st_d = PARITY != 0 ? PAR : STOP;
            end
            PAR: if (rx_samp) begin
                rx_pb_d = rx_s;
                rx_st_d = STOP;
            end
            STOP: if (rx_samp) begin
                rx_push = 1'b1;
                rx_st_d = rx_s ? IDLE : BRK;
            end
            default: if (rx_s) rx_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TA-1:0]] <= tx_data;
        if (rx_wr)   rx_mem[rx_wp_q[RA-1:0]] <= {rx_perr, rx_ferr, rx_sh_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_st_q  <= IDLE;
            tx_tk_q  <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            sync_q   <= 2'b11;
            rx_st_q  <= IDLE;
            rx_ph_q  <= '0;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
            rx_pb_q  <= 1'b0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_st_q  <= tx_st_d;
            tx_tk_q  <= tx_tk_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_par_q <= tx_par_d;
            sync_q   <= sync_d;
            rx_st_q  <= rx_st_d;
            rx_ph_q  <= rx_ph_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
            rx_pb_q  <= rx_pb_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            ovr_q    <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb_uart_fifo_transceiver: u0 is the default build with txd looped to rxd; u1 is PARITY=2 with 4-deep FIFOs
// and a bench-driven rxd. Line timing is derived from DIV=6, so one bit is 96 clk.
module tb_uart_fifo_transceiver;
    localparam int BIT = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       txd0, tx_valid0 = 1'b0, tx_ready0, rx_valid0, rx_ready0 = 1'b0, perr0, ferr0, ovr0;
    logic [7:0] tx_data0 = 8'h00, rx_data0;
    logic       rxd1 = 1'b1, txd1, tx_valid1 = 1'b0, tx_ready1, rx_valid1, rx_ready1 = 1'b0, perr1, ferr1, ovr1;
    logic [7:0] tx_data1 = 8'h00, rx_data1;
`ifdef UART_LOOPBACK_EN
    logic       lb0 = 1'b0;
`endif

    uart_fifo_transceiver u0 (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(lb0),
`endif
        .rxd(txd0), .txd(txd0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_overrun(ovr0)
    );

    uart_fifo_transceiver #(.PARITY(2), .TX_DEPTH(4), .RX_DEPTH(4)) u1 (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .rxd(rxd1), .txd(txd1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overrun(ovr1)
    );

    int ovr0_cnt = 0;
    int ovr1_cnt = 0;
    always @(posedge clk) begin
        if (ovr0) ovr0_cnt <= ovr0_cnt + 1;
        if (ovr1) ovr1_cnt <= ovr1_cnt + 1;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       pe;
        logic       fe;
    } vec_t;
    vec_t tbl [8];

    logic [7:0] rb [20];
    logic [7:0] tb6 [6];
    logic [7:0] dd;
    logic       dp, ds;
    int         t0, t_prev, lat, n, n_p, n_c, base, lowc;
    logic       prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    function automatic logic line(input int u);
        return u != 0 ? txd1 : txd0;
    endfunction

    // Bench-side receiver: finds the start edge, then samples every bit at its middle.
    task automatic dec(input int u, output logic [7:0] d, output logic p, output logic s, output int ts);
        int k = 0;
        while (line(u) !== 1'b0 && k < 3000) begin
            step(1);
            k++;
        end
        chk($sformatf("u%0d_start_seen", u), k < 3000, 1);
        ts = cyc;
        step(BIT / 2);
        chk($sformatf("u%0d_start_bit", u), line(u), 0);
        for (int i = 0; i < 8; i++) begin
            step(BIT);
            d[i] = line(u);
        end
        p = 1'b0;
        if (u != 0) begin
            step(BIT);
            p = line(u);
        end
        step(BIT);
        s = line(u);
    endtask

    task automatic send1(input logic [7:0] d, input logic p, input logic s);
        rxd1 = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd1 = d[i];
            step(BIT);
        end
        rxd1 = p;
        step(BIT);
        rxd1 = s;
        step(BIT);
    endtask

    task automatic pop1(input string nm, input logic [7:0] d, input logic pe, input logic fe);
        int k = 0;
        while (!rx_valid1 && k < 300) begin
            step(1);
            k++;
        end
        chk({nm, "_valid"}, rx_valid1, 1);
        chk({nm, "_data"}, rx_data1, d);
        chk({nm, "_perr"}, perr1, pe);
        chk({nm, "_ferr"}, ferr1, fe);
        rx_ready1 = 1'b1;
        step(1);
        rx_ready1 = 1'b0;
    endtask

    initial begin
        #(95_000 * 10);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{'{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0}, '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0},
                '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b0}, '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0},
                '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0},
                '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0}, '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1}};
        foreach (rb[i]) rb[i] = 8'($urandom);
        foreach (tb6[i]) tb6[i] = 8'($urandom);

        step(3);
        chk("rst_txd0", txd0, 1);
        chk("rst_tx_ready0", tx_ready0, 1);
        chk("rst_rx_valid0", rx_valid0, 0);
        chk("rst_errs0", {perr0, ferr0, ovr0}, 0);
        chk("rst_txd1", txd1, 1);
        chk("rst_tx_ready1", tx_ready1, 1);
        chk("rst_rx_valid1", rx_valid1, 0);
        rst = 1'b0;
        step(2);

        tx_data0 = 8'h55;
        tx_valid0 = 1'b1;
        step(1);
        tx_valid0 = 1'b0;
        chk("t1_tx_ready", tx_ready0, 1);
        lat = 0;
        while (txd0 !== 1'b0 && lat < 20) begin
            step(1);
            lat++;
        end
        chk($sformatf("t1_latency_%0d_le_8", lat), lat <= 8, 1);
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n = 0;
            while (txd0 === prev && n < 200) begin
                step(1);
                n++;
            end
            chk($sformatf("t1_bit%0d_len", i), n, BIT);
            prev = txd0;
        end
        n = 0;
        while (txd0 === 1'b1 && n < 150) begin
            step(1);
            n++;
        end
        chk("t1_stop_idle", n, 150);
        chk("t1_rx_valid", rx_valid0, 1);
        chk("t1_rx_data", rx_data0, 8'h55);
        chk("t1_rx_errs", {perr0, ferr0}, 0);
        rx_ready0 = 1'b1;
        step(1);
        rx_ready0 = 1'b0;

        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    n_p = 0;
                    while (!tx_ready0 && n_p < 3000) begin
                        step(1);
                        n_p++;
                    end
                    tx_data0 = rb[k];
                    tx_valid0 = 1'b1;
                    step(1);
                    tx_valid0 = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    dec(0, dd, dp, ds, t0);
                    chk($sformatf("rnd_txd_byte%0d", k), dd, rb[k]);
                    chk($sformatf("rnd_txd_stop%0d", k), ds, 1);
                end
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    n_c = 0;
                    while (!rx_valid0 && n_c < 3000) begin
                        step(1);
                        n_c++;
                    end
                    chk($sformatf("rnd_rx_valid%0d", k), rx_valid0, 1);
                    chk($sformatf("rnd_rx_byte%0d", k), rx_data0, rb[k]);
                    chk($sformatf("rnd_rx_errs%0d", k), {perr0, ferr0}, 0);
                    rx_ready0 = 1'b1;
                    step(1);
                    rx_ready0 = 1'b0;
                end
            end
        join

        foreach (tbl[i]) begin
            send1(tbl[i].d, tbl[i].p, tbl[i].s);
            rxd1 = 1'b1;
            step(30);
            pop1($sformatf("vec%0d", i), tbl[i].d, tbl[i].pe, tbl[i].fe);
            step(20);
        end

        send1(8'h3C, 1'b0, 1'b0);
        step(200);
        pop1("brk", 8'h3C, 1'b0, 1'b1);
        chk("brk_no_more_low", rx_valid1, 0);
        step(200);
        chk("brk_still_empty", rx_valid1, 0);
        rxd1 = 1'b1;
        step(150);
        chk("brk_empty_after_high", rx_valid1, 0);
        send1(8'h7E, 1'b0, 1'b1);
        step(20);
        pop1("brk_next", 8'h7E, 1'b0, 1'b0);

        rxd1 = 1'b0;
        step(40);
        rxd1 = 1'b1;
        step(200);
        chk("false_start_no_push", rx_valid1, 0);
        send1(8'h7E, 1'b0, 1'b1);
        step(20);
        pop1("false_start_next", 8'h7E, 1'b0, 1'b0);

        base = ovr1_cnt;
        for (int k = 1; k <= 5; k++) begin
            send1(8'(k), ^8'(k), 1'b1);
            step(20);
            if (k == 4) chk("ovr_none_at_4", ovr1_cnt - base, 0);
        end
        chk("ovr_once_at_5", ovr1_cnt - base, 1);
        for (int k = 1; k <= 4; k++) pop1($sformatf("ovr_pop%0d", k), 8'(k), 1'b0, 1'b0);
        chk("ovr_drained", rx_valid1, 0);

        fork
            begin
                tx_data1 = tb6[0];
                tx_valid1 = 1'b1;
                step(1);
                tx_valid1 = 1'b0;
                n_p = 0;
                while (txd1 !== 1'b0 && n_p < 200) begin
                    step(1);
                    n_p++;
                end
                for (int k = 1; k <= 4; k++) begin
                    chk($sformatf("t6_ready_before%0d", k), tx_ready1, 1);
                    tx_data1 = tb6[k];
                    tx_valid1 = 1'b1;
                    step(1);
                    tx_valid1 = 1'b0;
                end
                chk("t6_full", tx_ready1, 0);
                n_p = 0;
                while (!tx_ready1 && n_p < 3000) begin
                    step(1);
                    n_p++;
                end
                tx_data1 = tb6[5];
                tx_valid1 = 1'b1;
                step(1);
                tx_valid1 = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    dec(1, dd, dp, ds, t0);
                    chk($sformatf("t6_byte%0d", k), dd, tb6[k]);
                    chk($sformatf("t6_par%0d", k), dp, ^tb6[k]);
                    chk($sformatf("t6_stop%0d", k), ds, 1);
                    if (k > 0) chk($sformatf("t6_spacing%0d", k), t0 - t_prev, 11 * BIT);
                    t_prev = t0;
                end
            end
        join

`ifdef UART_LOOPBACK_EN
        lb0 = 1'b1;
        step(2);
        tx_data0 = 8'hC3;
        tx_valid0 = 1'b1;
        step(1);
        tx_valid0 = 1'b0;
        lowc = 0;
        for (int i = 0; i < 1200; i++) begin
            step(1);
            if (txd0 !== 1'b1) lowc++;
        end
        chk("lb_txd_held", lowc, 0);
        chk("lb_rx_valid", rx_valid0, 1);
        chk("lb_rx_data", rx_data0, 8'hC3);
        chk("lb_rx_errs", {perr0, ferr0}, 0);
        rx_ready0 = 1'b1;
        step(1);
        rx_ready0 = 1'b0;
        lb0 = 1'b0;
        step(2);
`endif

        step(100);
        foreach (tb6[i]) tb6[i] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tx_data1 = tb6[k];
            tx_valid1 = 1'b1;
            step(1);
        end
        tx_valid1 = 1'b0;
        n = 0;
        while (txd1 !== 1'b0 && n < 200) begin
            step(1);
            n++;
        end
        step(150);
        chk("rst_mid_frame_low", txd1, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_txd_immediate", txd1, 1);
        chk("rst_tx_ready", tx_ready1, 1);
        step(2);
        rst = 1'b0;
        lowc = 0;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if (txd1 !== 1'b1) lowc++;
        end
        chk("rst_tx_fifo_empty", lowc, 0);
        chk("rst_rx_fifo_empty", rx_valid1, 0);
        chk("u0_no_overrun", ovr0_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
